data_ram_responder: RTL

- Responder end of the CPU load/store data-memory interface. The CPU core is the initiator; this block accepts one request at a time.
- Byte-enabled word storage with a fixed, parameterised access latency and a valid/ready response handshake.
- Sits beside the instruction ROM inside min_sopc. The core's memory stage drives it, and the core stalls on req_ready / resp_valid.

---
 rtl/data_ram_pkg.sv | 23 ++
 rtl/data_ram_array.sv | 41 ++++
 rtl/data_ram_responder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/data_ram_pkg.sv
// Shared types and constants for the data RAM responder.
// Provides the FSM state encoding, byte-select constants and the bus widths
// used by data_ram_array and data_ram_responder.
package data_ram_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned SEL_W  = WORD_W / BYTE_W;
    localparam int unsigned CNT_W  = 4;

    localparam logic [SEL_W-1:0] SEL_BYTE0 = 4'b0001;
    localparam logic [SEL_W-1:0] SEL_BYTE1 = 4'b0010;
    localparam logic [SEL_W-1:0] SEL_BYTE2 = 4'b0100;
    localparam logic [SEL_W-1:0] SEL_BYTE3 = 4'b1000;
    localparam logic [SEL_W-1:0] SEL_WORD  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/data_ram_array.sv
// Single-port word storage with per-byte write enables and a registered read.
// Ports:
//   clk      rising-edge clock
//   en_i     access strobe; read register and enabled lanes update on this edge
//   we_i     byte-lane write enables (bit i -> bits [8i+7:8i])
//   addr_i   word index
//   wdata_i  write data
//   rdata_o  word read on the last enabled edge (pre-write contents)
module data_ram_array
    import data_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic [SEL_W-1:0]      we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WORD_W-1:0]     wdata_i,
    output logic [WORD_W-1:0]     rdata_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Storage has no reset; contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < SEL_W; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][BYTE_W*i +: BYTE_W] <= wdata_i[BYTE_W*i +: BYTE_W];
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_responder.sv
// Responder end of the CPU load/store data-memory interface.
// One request at a time: accept in IDLE, wait LATENCY cycles, access the array
// on the edge entering RESP, hold the response until the initiator consumes it.
// Optional build macro: DATA_RAM_RANGE_CHECK_EN flags accesses with any set
// address bit above the array as errors (resp_err=1, rdata=0, store dropped).
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake
//   req_we, req_addr,
//   req_sel, req_wdata        request attributes (captured at acceptance)
//   resp_valid/resp_ready     response handshake
//   resp_rdata, resp_err      response payload
module data_ram_responder
    import data_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [SEL_W-1:0]  req_sel,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 we_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [SEL_W-1:0]     sel_q;
    logic [WORD_W-1:0]    wdata_q;
    logic                 oor_q;

    logic                 ready_q, ready_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 rd_ok_q, rd_ok_d;

    logic                 accept_c;
    logic                 consume_c;
    logic                 go_resp_c;
    logic                 in_idle_c;
    logic                 req_oor_c;
    logic                 a_we_c;
    logic                 a_oor_c;
    logic [ADDR_WIDTH-1:0] a_idx_c;
    logic [SEL_W-1:0]     a_sel_c;
    logic [WORD_W-1:0]    a_wdata_c;
    logic [SEL_W-1:0]     mem_we_c;
    logic [WORD_W-1:0]    mem_rdata;

    // Range check on the live request; captured with the other attributes.
`ifdef DATA_RAM_RANGE_CHECK_EN
    assign req_oor_c = |req_addr[WORD_W-1:ADDR_WIDTH+2];
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];
`else
    assign req_oor_c = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[WORD_W-1:ADDR_WIDTH+2], req_addr[1:0]};
`endif

    assign in_idle_c = (state_q == IDLE);
    assign accept_c  = req_valid && ready_q;
    assign consume_c = (state_q == RESP) && valid_q && resp_ready;

    // With LATENCY==1 the access happens on the acceptance edge itself, so the
    // array must see the live request rather than the capture registers.
    assign go_resp_c = (in_idle_c && accept_c && (LATENCY == 1)) ||
                       ((state_q == WAIT) && (cnt_q == CNT_W'(1)));

    assign a_we_c    = in_idle_c ? req_we    : we_q;
    assign a_idx_c   = in_idle_c ? req_addr[ADDR_WIDTH+1:2] : idx_q;
    assign a_sel_c   = in_idle_c ? req_sel   : sel_q;
    assign a_wdata_c = in_idle_c ? req_wdata : wdata_q;
    assign a_oor_c   = in_idle_c ? req_oor_c : oor_q;
    assign mem_we_c  = (a_we_c && !a_oor_c) ? a_sel_c : '0;

    data_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .en_i    (go_resp_c),
        .we_i    (mem_we_c),
        .addr_i  (a_idx_c),
        .wdata_i (a_wdata_c),
        .rdata_o (mem_rdata)
    );

    // State, counter, captured attributes and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            oor_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rd_ok_q <= rd_ok_d;
            if (accept_c) begin
                we_q    <= req_we;
                idx_q   <= req_addr[ADDR_WIDTH+1:2];
                sel_q   <= req_sel;
                wdata_q <= req_wdata;
                oor_q   <= req_oor_c;
            end
        end
    end

    // Next-state and latency counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (consume_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response outputs: loaded on the edge entering RESP, held until consumed.
    always_comb begin
        ready_d = (state_d == IDLE);
        valid_d = valid_q;
        err_d   = err_q;
        rd_ok_d = rd_ok_q;
        if (go_resp_c) begin
            valid_d = 1'b1;
            err_d   = a_oor_c;
            rd_ok_d = !a_we_c && !a_oor_c;
        end else if (consume_c) begin
            valid_d = 1'b0;
            err_d   = 1'b0;
            rd_ok_d = 1'b0;
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_err   = err_q;
    // Read register is only meaningful for clean loads; zero otherwise.
    assign resp_rdata = rd_ok_q ? mem_rdata : '0;

endmodule
